// File: rtl/x2050_pkg.sv
// Shared 2050 constants: storage-function encodings, local-storage geometry,
// the LS sequencer state type and the per-byte odd-parity generator.
package x2050_pkg;

  localparam int LS_ADDR_W = 6;
  localparam int LS_DATA_W = 32;
  localparam int LS_PAR_W  = LS_DATA_W / 8;

  localparam logic [2:0] SF_R_LS      = 3'd0;
  localparam logic [2:0] SF_LS_L_R_LS = 3'd1;
  localparam logic [2:0] SF_LS_R      = 3'd2;
  localparam logic [2:0] SF_L_LS      = 3'd4;
  localparam logic [2:0] SF_LS_R_L_LS = 3'd5;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } ls_state_e;

  // One bit per byte, chosen so that each byte plus its bit holds an odd number of ones.
  function automatic logic [LS_PAR_W-1:0] odd_parity(input logic [LS_DATA_W-1:0] d);
    logic [LS_PAR_W-1:0] p;
    for (int i = 0; i < LS_PAR_W; i++) begin
      p[i] = ~^d[i*8 +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/x2050_lsarray.sv
// Local-storage RAM: one synchronous write port, one asynchronous read port.
// Contents are not reset; the clear sequencer in x2050_lstore zeroes them.
module x2050_lsarray #(
  parameter int ADDR_W = 6,
  parameter int WORD_W = 32
) (
  input  logic              i_clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [2**ADDR_W];

  always_ff @(posedge i_clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/x2050_lstore.sv
// 2050 local storage: SF write decode, one-deep write buffer with read bypass,
// post-reset clear sequencer. Optional parity enabled by X2050_LS_PARITY_EN.
//
// state    | meaning
// ST_CLEAR | zeroing array word clr_cnt each cycle, o_busy high
// ST_RUN   | normal SF reads/writes, stays until reset
module x2050_lstore
  import x2050_pkg::*;
#(
  parameter int ADDR_W = LS_ADDR_W,
  parameter int DATA_W = LS_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_ros_advance,
  input  logic [2:0]        i_sf,
  input  logic [ADDR_W-1:0] i_lsa,
  input  logic [DATA_W-1:0] i_r_reg,
  input  logic [DATA_W-1:0] i_l_reg,
  input  logic              i_break_out,
  output logic [DATA_W-1:0] o_ls,
  output logic              o_busy,
  output logic              o_parity_err
);

`ifdef X2050_LS_PARITY_EN
  localparam int WORD_W = DATA_W + DATA_W / 8;
`else
  localparam int WORD_W = DATA_W;
`endif

  ls_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              pend_v_q, pend_v_d;
  logic [ADDR_W-1:0] pend_a_q, pend_a_d;
  logic [DATA_W-1:0] pend_d_q, pend_d_d;

  logic              sf_write;
  logic              wr_issue;
  logic              bypass_hit;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_waddr;
  logic [WORD_W-1:0] arr_wdata;
  logic [WORD_W-1:0] arr_rdata;

  // FSM state register, clear counter and write buffer
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
      pend_v_q  <= 1'b0;
      pend_a_q  <= '0;
      pend_d_q  <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      pend_v_q  <= pend_v_d;
      pend_a_q  <= pend_a_d;
      pend_d_q  <= pend_d_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_comb begin
    o_busy = (state_q == ST_CLEAR);
  end

  // Break-out cycles only read LS; SF 1/5 read and write in the same cycle.
  always_comb begin
    sf_write = (i_sf == SF_R_LS) || (i_sf == SF_LS_L_R_LS) ||
               (i_sf == SF_L_LS) || (i_sf == SF_LS_R_L_LS);
    wr_issue = i_ros_advance && !o_busy && !i_break_out && sf_write;
  end

  always_comb begin
    pend_v_d = wr_issue;
    pend_a_d = pend_a_q;
    pend_d_d = pend_d_q;
    if (wr_issue) begin
      pend_a_d = i_lsa;
      pend_d_d = i_sf[2] ? i_l_reg : i_r_reg;
    end
  end

  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = pend_a_q;
`ifdef X2050_LS_PARITY_EN
    arr_wdata = {odd_parity(pend_d_q), pend_d_q};
`else
    arr_wdata = pend_d_q;
`endif
    if (!i_reset) begin
      if (state_q == ST_CLEAR) begin
        arr_we    = 1'b1;
        arr_waddr = clr_cnt_q;
`ifdef X2050_LS_PARITY_EN
        arr_wdata = {odd_parity('0), {DATA_W{1'b0}}};
`else
        arr_wdata = '0;
`endif
      end else if (pend_v_q) begin
        arr_we = 1'b1;
      end
    end
  end

  x2050_lsarray #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_array (
    .i_clk   (i_clk),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .raddr_i (i_lsa),
    .rdata_o (arr_rdata)
  );

  assign bypass_hit = pend_v_q && (pend_a_q == i_lsa);
  assign o_ls       = bypass_hit ? pend_d_q : arr_rdata[DATA_W-1:0];

`ifdef X2050_LS_PARITY_EN
  logic perr_q;
  logic rd_check;
  logic rd_bad;

  // Only words actually coming from the array are checked; the bypass path has no parity.
  assign rd_check = !o_busy && !bypass_hit &&
                    ((i_ros_advance && (i_sf == SF_LS_R || i_sf == SF_LS_R_L_LS)) || i_break_out);
  assign rd_bad   = odd_parity(arr_rdata[DATA_W-1:0]) != arr_rdata[WORD_W-1:DATA_W];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      perr_q <= 1'b0;
    end else if (rd_check && rd_bad) begin
      perr_q <= 1'b1;
    end
  end

  assign o_parity_err = perr_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_x2050_lstore.sv
// Directed self-checking bench for x2050_lstore; parity scenario only when
// X2050_LS_PARITY_EN is defined.
module tb_x2050_lstore;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_ros_advance;
  logic [2:0]  i_sf;
  logic [5:0]  i_lsa;
  logic [31:0] i_r_reg;
  logic [31:0] i_l_reg;
  logic        i_break_out;
  logic [31:0] o_ls;
  logic        o_busy;
  logic        o_parity_err;

  int checks   = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  x2050_lstore dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .i_ros_advance (i_ros_advance),
    .i_sf          (i_sf),
    .i_lsa         (i_lsa),
    .i_r_reg       (i_r_reg),
    .i_l_reg       (i_l_reg),
    .i_break_out   (i_break_out),
    .o_ls          (o_ls),
    .o_busy        (o_busy),
    .o_parity_err  (o_parity_err)
  );

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_ros_advance = 1'b0;
    i_sf          = 3'd2;
    i_r_reg       = '0;
    i_l_reg       = '0;
    i_break_out   = 1'b0;
  endtask

  task automatic test_reset();
    int busy_cycles;
    logic [5:0] addrs [3];
    idle_inputs();
    i_lsa   = '0;
    i_reset = 1'b1;
    step();
    step();
    checks++;
    if (o_busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_busy got=%b exp=1", o_busy);
    end
    checks++;
    if (o_parity_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_perr got=%b exp=0", o_parity_err);
    end
    i_reset = 1'b0;
    busy_cycles = 0;
    while (o_busy === 1'b1 && busy_cycles < 200) begin
      busy_cycles++;
      step();
    end
    checks++;
    if (busy_cycles !== 64) begin
      failures++;
      $display("FAIL clear_cycles got=%0d exp=64", busy_cycles);
    end
    addrs[0] = 6'd0; addrs[1] = 6'd5; addrs[2] = 6'd63;
    foreach (addrs[k]) begin
      i_lsa = addrs[k];
      #1;
      checks++;
      if (o_ls !== 32'h0) begin
        failures++;
        $display("FAIL cleared_word lsa=%0d got=%h exp=00000000", addrs[k], o_ls);
      end
    end
  endtask

  task automatic test_write_bypass();
    i_sf = 3'd0; i_lsa = 6'd5; i_r_reg = 32'hDEADBEEF; i_ros_advance = 1'b1;
    step();
    idle_inputs();
    #1;
    checks++;
    if (o_ls !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL write_bypass got=%h exp=deadbeef", o_ls);
    end
    step();
    checks++;
    if (o_ls !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL write_array got=%h exp=deadbeef", o_ls);
    end
  endtask

  task automatic test_read_then_write();
    i_sf = 3'd1; i_lsa = 6'd5; i_r_reg = 32'h12345678; i_ros_advance = 1'b1;
    #1;
    checks++;
    if (o_ls !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL rmw_old got=%h exp=deadbeef", o_ls);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (o_ls !== 32'h12345678) begin
      failures++;
      $display("FAIL rmw_new got=%h exp=12345678", o_ls);
    end
  endtask

  task automatic test_back_to_back();
    i_sf = 3'd4; i_lsa = 6'd3; i_l_reg = 32'h1; i_ros_advance = 1'b1;
    step();
    checks++;
    if (o_ls !== 32'h1) begin
      failures++;
      $display("FAIL b2b_first got=%h exp=00000001", o_ls);
    end
    i_l_reg = 32'h2;
    step();
    idle_inputs();
    #1;
    checks++;
    if (o_ls !== 32'h2) begin
      failures++;
      $display("FAIL b2b_bypass got=%h exp=00000002", o_ls);
    end
    step();
    checks++;
    if (o_ls !== 32'h2) begin
      failures++;
      $display("FAIL b2b_array got=%h exp=00000002", o_ls);
    end
    i_lsa = 6'd2;
    #1;
    checks++;
    if (o_ls !== 32'h0) begin
      failures++;
      $display("FAIL b2b_neighbour_lo got=%h exp=00000000", o_ls);
    end
    i_lsa = 6'd4;
    #1;
    checks++;
    if (o_ls !== 32'h0) begin
      failures++;
      $display("FAIL b2b_neighbour_hi got=%h exp=00000000", o_ls);
    end
  endtask

  task automatic test_no_write();
    logic [2:0] no_wr_sf [4];
    no_wr_sf[0] = 3'd2; no_wr_sf[1] = 3'd3; no_wr_sf[2] = 3'd6; no_wr_sf[3] = 3'd7;
    i_lsa = 6'd9; i_r_reg = 32'hAAAA5555; i_l_reg = 32'h5555AAAA;
    i_sf = 3'd0; i_ros_advance = 1'b0;
    step();
    i_ros_advance = 1'b1;
    foreach (no_wr_sf[k]) begin
      i_sf = no_wr_sf[k];
      step();
    end
    i_sf = 3'd0; i_break_out = 1'b1;
    step();
    i_sf = 3'd4;
    step();
    idle_inputs();
    i_lsa = 6'd9;
    step();
    step();
    checks++;
    if (o_ls !== 32'h0) begin
      failures++;
      $display("FAIL no_write_lsa9 got=%h exp=00000000", o_ls);
    end
    i_lsa = 6'd5;
    #1;
    checks++;
    if (o_ls !== 32'h12345678) begin
      failures++;
      $display("FAIL no_write_lsa5 got=%h exp=12345678", o_ls);
    end
    checks++;
    if (o_parity_err !== 1'b0) begin
      failures++;
      $display("FAIL no_write_perr got=%b exp=0", o_parity_err);
    end
  endtask

  task automatic test_reset_mid_clear();
    int busy_cycles;
    idle_inputs();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    repeat (20) step();
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    // Attempted writes while clearing must be discarded.
    i_sf = 3'd0; i_lsa = 6'd63; i_r_reg = 32'hFFFFFFFF; i_ros_advance = 1'b1;
    busy_cycles = 0;
    while (o_busy === 1'b1 && busy_cycles < 200) begin
      busy_cycles++;
      step();
    end
    idle_inputs();
    checks++;
    if (busy_cycles !== 64) begin
      failures++;
      $display("FAIL restart_cycles got=%0d exp=64", busy_cycles);
    end
    step();
    i_lsa = 6'd63;
    #1;
    checks++;
    if (o_ls !== 32'h0) begin
      failures++;
      $display("FAIL busy_write_ignored got=%h exp=00000000", o_ls);
    end
    i_lsa = 6'd5;
    #1;
    checks++;
    if (o_ls !== 32'h0) begin
      failures++;
      $display("FAIL recleared_lsa5 got=%h exp=00000000", o_ls);
    end
  endtask

`ifdef X2050_LS_PARITY_EN
  task automatic test_parity();
    dut.u_array.mem_q[7] = dut.u_array.mem_q[7] ^ (40'h1 << 32);
    i_lsa = 6'd7; i_sf = 3'd2; i_ros_advance = 1'b1;
    step();
    idle_inputs();
    #1;
    checks++;
    if (o_parity_err !== 1'b1) begin
      failures++;
      $display("FAIL parity_set got=%b exp=1", o_parity_err);
    end
    i_lsa = 6'd0;
    step();
    step();
    checks++;
    if (o_parity_err !== 1'b1) begin
      failures++;
      $display("FAIL parity_sticky got=%b exp=1", o_parity_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_bypass();
    test_read_then_write();
    test_back_to_back();
    test_no_write();
    test_reset_mid_clear();
`ifdef X2050_LS_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
